multi_read_port_lutram: RTL and testbench
=========================================

Name: multi_read_port_lutram

Overview:
Distributed-RAM storage with one byte-masked write port and NUM_READ_PORT independent registered read ports. Each read port has its own valid tracking. On reset, a hardware init sequencer sweeps the array to zero. A single-cycle flush invalidates every entry. It serves as the shared building block for multi-issue register-file-like tables (TLB tags, branch tables) that need several same-cycle lookups.

Parameters:
SINGLE_ENTRY_WIDTH_IN_BITS, 64, entry width; must be a multiple of `BYTE_LEN_IN_BITS.
NUM_SET, 64, number of entries; must be a power of 2, >= 2.
SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), address width.
WRITE_MASK_LEN, SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS, byte-enable count.
NUM_READ_PORT, 2, number of read ports; must be >= 1.
CONFIG_MODE, "ReadFirst", "ReadFirst" or "WriteFirst"; applies uniformly to all read ports.

Ports:
clk_in  input  1  clock; all logic is on the rising edge.
reset_in  input  1  reset, asynchronous and active-low.
flush_in  input  1  invalidate all entries; honoured only when ready_out=1.
ready_out  output  1  1 = init sweep done and accesses are accepted.
write_port_access_en_in  input  1  write request.
write_port_write_en_in  input  WRITE_MASK_LEN  byte enables.
write_port_access_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write address.
write_port_data_in  input  SINGLE_ENTRY_WIDTH_IN_BITS  write data.
read_port_access_en_in  input  NUM_READ_PORT  per-port read request.
read_port_access_set_addr_in  input  NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS  packed addresses; port p occupies slice p.
read_port_data_out  output  NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS  packed read data.
read_port_valid_out  output  NUM_READ_PORT  per-port valid of the returned entry.

Behaviour:
- Reset asserted (async, low):
  - ready_out=0; all read_port_data_out=0; all read_port_valid_out=0.
  - valid_array cleared; init pointer=0; state=INIT.
- State INIT:
  - Each cycle writes all-zero to lutram[init_ptr]; init_ptr increments.
  - After entry NUM_SET-1 is written, state becomes IDLE on the next edge and ready_out=1 from then.
  - Sweep takes exactly NUM_SET cycles after reset deassertion.
  - Write, read and flush inputs are ignored; read outputs are held at 0/0.
- State IDLE: normal operation; there is no return to INIT except by reset.
- Write (IDLE, en=1, mask!=0):
  - Enabled bytes update at the clock edge; other bytes are unchanged.
  - valid_array[addr] is set to 1.
  - mask==0 is a no-op and does not set valid.
- Read, port p:
  - Latency is 1 cycle.
  - en=1: data/valid registered from addr_p.
  - en=0: data=0, valid=0 next cycle.
  - Any number of ports may read the same address in the same cycle.
- ReadFirst mode: a same-cycle write to the same address returns the pre-write entry and pre-write valid.
- WriteFirst mode, same-address forwarding (write en, mask!=0, addr equal):
  - Returned data takes enabled bytes from write_port_data_in and the remaining bytes from the stored entry (merged, not zero-filled).
  - Returned valid=1.
- Flush (IDLE):
  - Clears all valid bits at the edge; data contents are untouched.
  - Reads sampled in the flush cycle still see pre-flush valid, except WriteFirst forwarding, which returns valid=1.
  - Flush together with a write: data is written but its valid bit ends cleared (flush wins).
- Reset mid-INIT or mid-operation: returns immediately to the reset state and restarts the sweep from 0.
- Storage carries (* ram_style = "distributed" *); the valid array is flops.

Decomposition:
- Shared package / parameters.h:
  - `BYTE_LEN_IN_BITS (existing).
  - Mode string constants READ_FIRST / WRITE_FIRST.
  - INIT/IDLE state encoding (1 bit).
- One sub-module, lutram_read_port, instantiated NUM_READ_PORT times via generate. Per port it handles:
  - address-match detection;
  - byte-merge forwarding;
  - output data/valid registers.
- The top level holds the storage array, valid array, init sequencer and flush.

Test Plan:
- Init/reset: deassert reset, NUM_SET=64 -> ready_out rises exactly 64 cycles later. Then a read of any address returns data 0, valid 0. Writes issued during INIT are not stored.
- Masked write: write addr 5, data 0x1122334455667788, mask 0x0F; later read on port 0 -> 0x0000000055667788, valid=1.
- Dual read: port 0 reads addr 5 while port 1 reads addr 6 (never written) -> port 0 gets the data with valid 1; port 1 gets 0 with valid 0; both one cycle after the request.
- Same-address collision:
  - Setup: addr 9 holds 0xAAAA...AA; same cycle, write 0xBBBB...BB with mask 0xF0 and read addr 9 on both ports.
  - ReadFirst -> 0xAAAA...AA on both ports.
  - WriteFirst -> 0xBBBBBBBBAAAAAAAA, valid=1 on both ports.
- Flush: write addr 3, then pulse flush_in together with a write to addr 4. Read 3 and 4 next cycle -> valid=0 on both; data of addr 4 equals the written value.
- Reset mid-operation: pull reset low two cycles into traffic -> outputs 0 and ready_out 0 immediately (async). After release, the sweep reruns for 64 cycles and previously written entries read as 0/invalid.

Source files
------------

// File: rtl/multi_read_port_lutram_pkg.sv
// Shared constants for the multi-read-port LUTRAM: byte size, read-mode
// selectors and the init/idle state encoding.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

package multi_read_port_lutram_pkg;
    localparam int BYTE_LEN = `BYTE_LEN_IN_BITS;

    localparam logic [79:0] READ_FIRST  = {8'h00, "ReadFirst"};
    localparam logic [79:0] WRITE_FIRST = "WriteFirst";

    localparam logic [0:0] STATE_INIT = 1'b0;
    localparam logic [0:0] STATE_IDLE = 1'b1;
endpackage

// File: rtl/multi_read_port_lutram_if.sv
// Access bus of the multi-read-port LUTRAM: flush, one masked write port and
// NUM_RD packed read ports.
interface multi_read_port_lutram_if
    import multi_read_port_lutram_pkg::*;
#(
    parameter int ENTRY_W = 64,
    parameter int ADDR_W  = 6,
    parameter int NUM_RD  = 2
);
    localparam int MASK_W = ENTRY_W / BYTE_LEN;

    logic                      flush_in;
    logic                      ready_out;
    logic                      write_port_access_en_in;
    logic [MASK_W-1:0]         write_port_write_en_in;
    logic [ADDR_W-1:0]         write_port_access_set_addr_in;
    logic [ENTRY_W-1:0]        write_port_data_in;
    logic [NUM_RD-1:0]         read_port_access_en_in;
    logic [NUM_RD*ADDR_W-1:0]  read_port_access_set_addr_in;
    logic [NUM_RD*ENTRY_W-1:0] read_port_data_out;
    logic [NUM_RD-1:0]         read_port_valid_out;

    modport master (
        output flush_in, write_port_access_en_in, write_port_write_en_in,
               write_port_access_set_addr_in, write_port_data_in,
               read_port_access_en_in, read_port_access_set_addr_in,
        input  ready_out, read_port_data_out, read_port_valid_out
    );

    modport slave (
        input  flush_in, write_port_access_en_in, write_port_write_en_in,
               write_port_access_set_addr_in, write_port_data_in,
               read_port_access_en_in, read_port_access_set_addr_in,
        output ready_out, read_port_data_out, read_port_valid_out
    );
endinterface

// File: rtl/multi_read_port_lutram_read_port.sv
// One registered read port: optional same-address write forwarding with
// byte merge, then the output data/valid registers.
module lutram_read_port
    import multi_read_port_lutram_pkg::*;
#(
    parameter int ENTRY_W = 64,
    parameter int ADDR_W  = 6,
    parameter int MASK_W  = ENTRY_W / BYTE_LEN,
    parameter bit FORWARD = 1'b0
)(
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               ready,
    input  logic               access_en,
    input  logic [ADDR_W-1:0]  access_addr,
    input  logic [ENTRY_W-1:0] stored_data,
    input  logic               stored_valid,
    input  logic               write_fire,
    input  logic [MASK_W-1:0]  write_mask,
    input  logic [ADDR_W-1:0]  write_addr,
    input  logic [ENTRY_W-1:0] write_data,
    output logic [ENTRY_W-1:0] data,
    output logic               valid
);
    logic               hit;
    logic [ENTRY_W-1:0] merged;

    assign hit = FORWARD && write_fire && (write_addr == access_addr);

    always_comb begin
        merged = stored_data;
        if (hit) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (write_mask[b]) merged[b*BYTE_LEN +: BYTE_LEN] = write_data[b*BYTE_LEN +: BYTE_LEN];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (!ready || !access_en) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            data  <= merged;
            valid <= hit | stored_valid;
        end
    end
endmodule

// File: rtl/multi_read_port_lutram.sv
// Distributed-RAM table with one byte-masked write port, NUM_READ_PORT
// registered read ports, per-entry valid bits, zeroing init sweep and flush.
//
// state      | meaning
// STATE_INIT | sweeping zeros into lutram[init_ptr]; all accesses ignored
// STATE_IDLE | ready_out=1, normal read/write/flush
module multi_read_port_lutram
    import multi_read_port_lutram_pkg::*;
#(
    parameter int          SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int          NUM_SET                    = 64,
    parameter int          SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int          WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN,
    parameter int          NUM_READ_PORT              = 2,
    parameter logic [79:0] CONFIG_MODE                = READ_FIRST
)(
    input logic                    clk_in,
    input logic                    reset_in,
    multi_read_port_lutram_if.slave bus
);
    localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int AW = SET_PTR_WIDTH_IN_BITS;
    localparam bit FORWARD = (CONFIG_MODE == WRITE_FIRST);

    (* ram_style = "distributed" *) logic [W-1:0] lutram [NUM_SET];
    logic [NUM_SET-1:0] valid_array;
    logic [0:0]         state;
    logic [AW-1:0]      init_ptr;
    logic               ready;
    logic               wr_fire;
    logic [AW-1:0]      wr_addr;

    assign ready         = (state == STATE_IDLE);
    assign bus.ready_out = ready;
    assign wr_addr       = bus.write_port_access_set_addr_in;
    assign wr_fire       = ready & bus.write_port_access_en_in & (|bus.write_port_write_en_in);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state    <= STATE_INIT;
            init_ptr <= '0;
        end else if (state == STATE_INIT) begin
            init_ptr <= init_ptr + AW'(1);
            if (init_ptr == AW'(NUM_SET - 1)) state <= STATE_IDLE;
        end
    end

    // Storage has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk_in) begin
        if (state == STATE_INIT) begin
            lutram[init_ptr] <= '0;
        end else if (wr_fire) begin
            for (int b = 0; b < WRITE_MASK_LEN; b++) begin
                if (bus.write_port_write_en_in[b])
                    lutram[wr_addr][b*BYTE_LEN +: BYTE_LEN] <= bus.write_port_data_in[b*BYTE_LEN +: BYTE_LEN];
            end
        end
    end

    // Flush takes priority over the valid-set of a concurrent write.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            valid_array <= '0;
        end else if (ready) begin
            if (bus.flush_in)  valid_array          <= '0;
            else if (wr_fire)  valid_array[wr_addr] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORT; p++) begin : g_rd
        logic [AW-1:0] rd_addr;
        logic [W-1:0]  rd_data;
        logic          rd_valid;

        assign rd_addr = bus.read_port_access_set_addr_in[p*AW +: AW];

        lutram_read_port #(
            .ENTRY_W (W),
            .ADDR_W  (AW),
            .MASK_W  (WRITE_MASK_LEN),
            .FORWARD (FORWARD)
        ) u_rd (
            .clk_in       (clk_in),
            .reset_in     (reset_in),
            .ready        (ready),
            .access_en    (bus.read_port_access_en_in[p]),
            .access_addr  (rd_addr),
            .stored_data  (lutram[rd_addr]),
            .stored_valid (valid_array[rd_addr]),
            .write_fire   (wr_fire),
            .write_mask   (bus.write_port_write_en_in),
            .write_addr   (wr_addr),
            .write_data   (bus.write_port_data_in),
            .data         (rd_data),
            .valid        (rd_valid)
        );

        assign bus.read_port_data_out[p*W +: W] = rd_data;
        assign bus.read_port_valid_out[p]       = rd_valid;
    end
endmodule

// File: tb/tb_multi_read_port_lutram.sv
// Directed bench driving a ReadFirst and a WriteFirst instance with identical
// stimulus and comparing both against hand-computed values.
module tb_multi_read_port_lutram;
    import multi_read_port_lutram_pkg::*;

    localparam int W  = 64;
    localparam int NS = 64;
    localparam int AW = 6;
    localparam int NR = 2;
    localparam int MW = W / BYTE_LEN;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             flush       = 1'b0;
    logic             wr_en       = 1'b0;
    logic [MW-1:0]    wr_mask     = '0;
    logic [AW-1:0]    wr_addr     = '0;
    logic [W-1:0]     wr_data     = '0;
    logic [NR-1:0]    rd_en       = '0;
    logic [NR*AW-1:0] rd_addr_bus = '0;

    int checks = 0;
    int errors = 0;

    multi_read_port_lutram_if #(.ENTRY_W(W), .ADDR_W(AW), .NUM_RD(NR)) bus_rf ();
    multi_read_port_lutram_if #(.ENTRY_W(W), .ADDR_W(AW), .NUM_RD(NR)) bus_wf ();

    assign bus_rf.flush_in                      = flush;
    assign bus_rf.write_port_access_en_in       = wr_en;
    assign bus_rf.write_port_write_en_in        = wr_mask;
    assign bus_rf.write_port_access_set_addr_in = wr_addr;
    assign bus_rf.write_port_data_in            = wr_data;
    assign bus_rf.read_port_access_en_in        = rd_en;
    assign bus_rf.read_port_access_set_addr_in  = rd_addr_bus;
    assign bus_wf.flush_in                      = flush;
    assign bus_wf.write_port_access_en_in       = wr_en;
    assign bus_wf.write_port_write_en_in        = wr_mask;
    assign bus_wf.write_port_access_set_addr_in = wr_addr;
    assign bus_wf.write_port_data_in            = wr_data;
    assign bus_wf.read_port_access_en_in        = rd_en;
    assign bus_wf.read_port_access_set_addr_in  = rd_addr_bus;

    multi_read_port_lutram #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(W), .NUM_SET(NS), .NUM_READ_PORT(NR), .CONFIG_MODE(READ_FIRST)
    ) u_dut_rf (.clk_in(clk), .reset_in(rst_n), .bus(bus_rf));

    multi_read_port_lutram #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(W), .NUM_SET(NS), .NUM_READ_PORT(NR), .CONFIG_MODE(WRITE_FIRST)
    ) u_dut_wf (.clk_in(clk), .reset_in(rst_n), .bus(bus_wf));

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rf_data(input int p);
        return bus_rf.read_port_data_out[p*W +: W];
    endfunction
    function automatic logic [W-1:0] wf_data(input int p);
        return bus_wf.read_port_data_out[p*W +: W];
    endfunction

    task automatic check_port(input string tag, input int p,
                              input logic [W-1:0] rf_d, input logic rf_v,
                              input logic [W-1:0] wf_d, input logic wf_v);
        check_val($sformatf("%s_p%0d_rf_data",  tag, p), rf_data(p), rf_d);
        check_val($sformatf("%s_p%0d_rf_valid", tag, p), W'(bus_rf.read_port_valid_out[p]), W'(rf_v));
        check_val($sformatf("%s_p%0d_wf_data",  tag, p), wf_data(p), wf_d);
        check_val($sformatf("%s_p%0d_wf_valid", tag, p), W'(bus_wf.read_port_valid_out[p]), W'(wf_v));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_mask = '0;
        rd_en   = '0;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [MW-1:0] m);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mask = m;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
        rd_en[p] = en;
        rd_addr_bus[p*AW +: AW] = a;
    endtask

    // Counts rising edges after reset release until ready_out is seen.
    task automatic wait_ready(input string tag, input int start);
        int n;
        n = start;
        while (!bus_rf.ready_out && n < 200) begin
            tick();
            n++;
        end
        check_val({tag, "_rf_cycles"}, W'(n), W'(NS));
        check_val({tag, "_wf_ready"}, W'(bus_wf.ready_out), W'(1));
    endtask

    initial begin
        idle();
        #12;
        check_val("rst_rf_ready", W'(bus_rf.ready_out), W'(0));
        check_val("rst_wf_ready", W'(bus_wf.ready_out), W'(0));
        for (int p = 0; p < NR; p++) check_port("rst", p, '0, 1'b0, '0, 1'b0);

        // Release reset, then try to write/read/flush while the sweep runs.
        @(negedge clk);
        rst_n = 1'b1;
        drive_write(6'd7, {8{8'hFF}}, 8'hFF);
        flush = 1'b1;
        set_rd(0, 1'b1, 6'd7);
        set_rd(1, 1'b1, 6'd7);
        tick();
        tick();
        check_port("init_hold", 0, '0, 1'b0, '0, 1'b0);
        check_port("init_hold", 1, '0, 1'b0, '0, 1'b0);
        idle();
        wait_ready("init", 2);

        set_rd(0, 1'b1, 6'd7);
        set_rd(1, 1'b1, 6'd63);
        tick();
        idle();
        check_port("post_init", 0, '0, 1'b0, '0, 1'b0);
        check_port("post_init", 1, '0, 1'b0, '0, 1'b0);

        drive_write(6'd5, 64'h1122334455667788, 8'h0F);
        tick();
        idle();
        set_rd(0, 1'b1, 6'd5);
        set_rd(1, 1'b1, 6'd6);
        tick();
        idle();
        check_port("masked", 0, 64'h0000000055667788, 1'b1, 64'h0000000055667788, 1'b1);
        check_port("unwritten", 1, '0, 1'b0, '0, 1'b0);
        tick();
        check_port("rd_off", 0, '0, 1'b0, '0, 1'b0);

        drive_write(6'd9, {8{8'hAA}}, 8'hFF);
        tick();
        drive_write(6'd9, {8{8'hBB}}, 8'hF0);
        set_rd(0, 1'b1, 6'd9);
        set_rd(1, 1'b1, 6'd9);
        tick();
        idle();
        for (int p = 0; p < NR; p++)
            check_port("collide", p, {8{8'hAA}}, 1'b1, 64'hBBBBBBBBAAAAAAAA, 1'b1);
        set_rd(0, 1'b1, 6'd9);
        tick();
        idle();
        check_port("after_collide", 0, 64'hBBBBBBBBAAAAAAAA, 1'b1, 64'hBBBBBBBBAAAAAAAA, 1'b1);

        drive_write(6'd10, {8{8'hFF}}, 8'h00);
        set_rd(1, 1'b1, 6'd10);
        tick();
        idle();
        check_port("mask0_same", 1, '0, 1'b0, '0, 1'b0);
        set_rd(1, 1'b1, 6'd10);
        tick();
        idle();
        check_port("mask0_after", 1, '0, 1'b0, '0, 1'b0);

        drive_write(6'd11, 64'h123456789ABCDE5A, 8'h01);
        set_rd(0, 1'b1, 6'd11);
        tick();
        idle();
        check_port("fwd_invalid", 0, '0, 1'b0, 64'h000000000000005A, 1'b1);

        drive_write(6'd3, 64'hDEADBEEF01234567, 8'hFF);
        tick();
        flush = 1'b1;
        drive_write(6'd4, 64'hCAFEF00D8899AABB, 8'hFF);
        set_rd(0, 1'b1, 6'd3);
        set_rd(1, 1'b1, 6'd4);
        tick();
        idle();
        check_port("flush_cycle", 0, 64'hDEADBEEF01234567, 1'b1, 64'hDEADBEEF01234567, 1'b1);
        check_port("flush_cycle", 1, '0, 1'b0, 64'hCAFEF00D8899AABB, 1'b1);
        set_rd(0, 1'b1, 6'd3);
        set_rd(1, 1'b1, 6'd4);
        tick();
        idle();
        check_port("post_flush", 0, 64'hDEADBEEF01234567, 1'b0, 64'hDEADBEEF01234567, 1'b0);
        check_port("post_flush", 1, 64'hCAFEF00D8899AABB, 1'b0, 64'hCAFEF00D8899AABB, 1'b0);

        drive_write(6'd20, 64'h0F1E2D3C4B5A6978, 8'hFF);
        tick();
        idle();
        set_rd(0, 1'b1, 6'd20);
        set_rd(1, 1'b1, 6'd20);
        tick();
        check_port("pre_reset", 0, 64'h0F1E2D3C4B5A6978, 1'b1, 64'h0F1E2D3C4B5A6978, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_rf_ready", W'(bus_rf.ready_out), W'(0));
        check_val("midrst_wf_ready", W'(bus_wf.ready_out), W'(0));
        for (int p = 0; p < NR; p++) check_port("midrst", p, '0, 1'b0, '0, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("resweep", 0);
        set_rd(0, 1'b1, 6'd20);
        set_rd(1, 1'b1, 6'd5);
        tick();
        idle();
        check_port("resweep", 0, '0, 1'b0, '0, 1'b0);
        check_port("resweep", 1, '0, 1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
